sys_cmd_decoder: RTL and testbench
==================================

Name: sys_cmd_decoder

Overview:
- Consumes the synchronised byte stream (rx_data plus one-cycle rx_valid) produced by the data-synchroniser stage in the reference clock domain.
- Parses UART command frames into register-file write/read requests and ALU requests.
- Sits between the data synchroniser and the register file / ALU, as the receive half of the system controller.
- Detects malformed frames and stalled frames (timeout), aborts them, and flags the error.

Parameters:
- DATA_WIDTH, 8, width of received bytes and register-file data.
- ADDR_WIDTH, 4, register-file address width; address bytes must fit in it.
- TIMEOUT_CYCLES, 1024, clk cycles allowed between bytes of one frame before abort; must be >= 2.

Ports:
- clk  in  1  reference-domain clock
- rst  in  1  reset, synchronous, active-low
- rx_data  in  DATA_WIDTH  synchronised byte; valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per byte; back-to-back strobes allowed
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_data  out  DATA_WIDTH  register-file write data
- rf_wr_en  out  1  one-cycle write strobe
- rf_rd_en  out  1  one-cycle read strobe
- alu_fun  out  4  ALU function code
- alu_en  out  1  one-cycle ALU start strobe
- frame_busy  out  1  high while a frame is partially received
- cmd_err  out  1  one-cycle error strobe

Behaviour:
- Reset: on a rising clk edge with rst=0, the FSM goes to IDLE and the timer clears. All outputs become 0 (rf_addr, rf_wr_data, alu_fun, strobes, frame_busy, cmd_err). Reset mid-frame discards the partial frame and raises no cmd_err.
- Opcodes (first byte in IDLE):
  - 0xAA RF write: addr byte, then data byte.
  - 0xBB RF read: addr byte.
  - 0xCC ALU with operands: opA byte, opB byte, fun byte.
  - 0xDD ALU without operands: fun byte.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUN.
  - IDLE: 0xAA goes to WR_ADDR, 0xBB to RD_ADDR, 0xCC to OPA, 0xDD to ALU_FUN.
  - Any other opcode pulses cmd_err and stays in IDLE.
  - A state advances only on a cycle with rx_valid=1.
- Output latency: every output is registered. A strobe asserts the cycle after the completing byte is sampled and lasts exactly 1 cycle. rf_addr, rf_wr_data and alu_fun hold their last value until next updated.
- WR_ADDR: latch the address, go to WR_DATA. WR_DATA: rf_wr_data=byte, rf_wr_en pulse, go to IDLE.
- RD_ADDR: rf_addr=byte, rf_rd_en pulse, go to IDLE.
- OPA: rf_addr=0, rf_wr_data=byte, rf_wr_en pulse, go to OPB.
- OPB: rf_addr=1, rf_wr_data=byte, rf_wr_en pulse, go to ALU_FUN.
- ALU_FUN: alu_fun=byte[3:0], alu_en pulse, go to IDLE.
- Address range check: an address byte with any bit at or above ADDR_WIDTH set pulses cmd_err, aborts to IDLE, and issues no strobe.
- Function range check: a fun byte with byte[7:4] != 0 pulses cmd_err, aborts to IDLE, and issues no alu_en.
- Back-to-back bytes: a new opcode may arrive in the cycle right after a frame's final byte. It is decoded normally and the strobes do not overlap.
- frame_busy = (state != IDLE), registered. It is 0 in the cycle after the final byte is sampled.
- Timeout:
  - Counter clears on every accepted byte and counts while state != IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 with no rx_valid: cmd_err pulses, FSM returns to IDLE, and no strobes are issued for the partial frame.
  - rx_valid in the expiry cycle wins: the byte is accepted and there is no timeout.
- Error-strobe exclusivity: at most one of rf_wr_en, rf_rd_en, alu_en, cmd_err is high in any cycle.
- The OPB write and the ALU_FUN alu_en are issued in separate cycles.

Decomposition:
- Package sys_cmd_pkg holds:
  - opcode localparams CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - OPA_ADDR=0, OPB_ADDR=1;
  - the state enum typedef.
- One sub-module, sys_cmd_frame_timer: a counter with clear, count-enable and expire outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- RF write: bytes AA,05,3C with rx_valid 2 cycles apart -> 1 cycle after the 3C sample, rf_wr_en=1, rf_addr=5, rf_wr_data=3C. frame_busy high from the AA sample until the 3C sample.
- RF read plus back-to-back: AA,02,11 then BB,07 on consecutive cycles -> rf_wr_en pulse (addr 2, data 11), then rf_rd_en pulse (addr 7). No overlap, no cmd_err.
- ALU with operands: CC,0A,14,03 -> wr pulse (addr 0, data 0A), wr pulse (addr 1, data 14), then alu_en with alu_fun=3. Then DD,01 -> alu_en with alu_fun=1.
- Errors:
  - opcode 55 in IDLE -> cmd_err pulse, state stays IDLE;
  - BB,1F -> cmd_err, no rf_rd_en;
  - DD,20 -> cmd_err, no alu_en.
- Timeout (TIMEOUT_CYCLES=16): AA,04 then silence -> cmd_err 16 cycles after the 04 sample, frame_busy low. A following BB,04 is decoded correctly. Repeat with a byte arriving exactly in the expiry cycle -> no cmd_err.
- Reset mid-frame: CC,0A, then rst=0 for 1 cycle -> all outputs 0, FSM in IDLE, no strobes. A following AA,01,FF -> rf_wr_en with addr 1, data FF.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the UART command decoder.
// Holds the opcode bytes, the fixed operand register addresses and the frame FSM state type.
// Imported by sys_cmd_decoder; no ports.
package sys_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots that receive the ALU operands.
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OPA,
    ST_OPB,
    ST_ALU_FUN
  } state_t;

endpackage

// File: rtl/sys_cmd_frame_timer.sv
// Inter-byte timer: counts idle cycles inside a frame and flags when the budget is spent.
// Ports: clk/rst (sync, active-low), clear restarts at 0, count_en advances,
// expire is high while the count sits at TIMEOUT_CYCLES-1 (the count saturates there).
module sys_cmd_frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (count_en && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sys_cmd_decoder.sv
// Receive half of the system controller: parses UART command frames into
// register-file write/read requests and ALU starts, aborting malformed or stalled frames.
// Ports: clk/rst (sync, active-low); rx_data/rx_valid byte stream in; rf_addr, rf_wr_data,
// rf_wr_en, rf_rd_en, alu_fun, alu_en, frame_busy, cmd_err out, all registered.
module sys_cmd_decoder
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [3:0]            alu_fun,
  output logic                  alu_en,
  output logic                  frame_busy,
  output logic                  cmd_err
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  in_frame;
  logic                  expire;
  logic                  timeout;
  logic                  addr_ok;
  logic                  fun_ok;

  assign in_frame = (state != ST_IDLE);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout  = in_frame && expire && !rx_valid;
  assign addr_ok  = ((rx_data >> ADDR_WIDTH) == '0);
  assign fun_ok   = (rx_data[DATA_WIDTH-1:4] == '0);

  sys_cmd_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (rx_valid || !in_frame),
    .count_en (in_frame),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      frame_busy <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      // Strobes are single-cycle; at most one is set on any given edge.
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      cmd_err  <= 1'b0;

      if (timeout) begin
        state      <= ST_IDLE;
        frame_busy <= 1'b0;
        cmd_err    <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            frame_busy <= 1'b1;
            case (rx_data)
              CMD_RF_WR:   state <= ST_WR_ADDR;
              CMD_RF_RD:   state <= ST_RD_ADDR;
              CMD_ALU_OP:  state <= ST_OPA;
              CMD_ALU_NOP: state <= ST_ALU_FUN;
              default: begin
                frame_busy <= 1'b0;
                cmd_err    <= 1'b1;
              end
            endcase
          end
          // The address is held privately so rf_addr only moves with a strobe.
          ST_WR_ADDR: begin
            if (addr_ok) begin
              addr_q <= rx_data[ADDR_WIDTH-1:0];
              state  <= ST_WR_DATA;
            end else begin
              state      <= ST_IDLE;
              frame_busy <= 1'b0;
              cmd_err    <= 1'b1;
            end
          end
          ST_WR_DATA: begin
            rf_addr    <= addr_q;
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
          end
          ST_RD_ADDR: begin
            if (addr_ok) begin
              rf_addr  <= rx_data[ADDR_WIDTH-1:0];
              rf_rd_en <= 1'b1;
            end else begin
              cmd_err  <= 1'b1;
            end
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
          end
          ST_OPA: begin
            rf_addr    <= ADDR_WIDTH'(OPA_ADDR);
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_OPB;
          end
          ST_OPB: begin
            rf_addr    <= ADDR_WIDTH'(OPB_ADDR);
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            if (fun_ok) begin
              alu_fun <= rx_data[3:0];
              alu_en  <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed bench for sys_cmd_decoder with a 16-cycle frame timeout.
// Inputs change just after the falling edge; outputs are read 1 time unit after it.
// Strobe overlap and error strobes are tallied by a monitor and checked at the end.
module tb_sys_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [3:0] alu_fun;
  logic       alu_en;
  logic       frame_busy;
  logic       cmd_err;

  int n_chk  = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int ovl_cnt = 0;

  sys_cmd_decoder #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .alu_fun    (alu_fun),
    .alu_en     (alu_en),
    .frame_busy (frame_busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_err) err_cnt <= err_cnt + 1;
    if ((32'(rf_wr_en) + 32'(rf_rd_en) + 32'(alu_en) + 32'(cmd_err)) > 1)
      ovl_cnt <= ovl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one cycle of input; returns once the resulting outputs are visible.
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rf_addr"}, 32'(rf_addr), 0);
    chk({tag, ".rf_wr_data"}, 32'(rf_wr_data), 0);
    chk({tag, ".rf_wr_en"}, 32'(rf_wr_en), 0);
    chk({tag, ".rf_rd_en"}, 32'(rf_rd_en), 0);
    chk({tag, ".alu_fun"}, 32'(alu_fun), 0);
    chk({tag, ".alu_en"}, 32'(alu_en), 0);
    chk({tag, ".frame_busy"}, 32'(frame_busy), 0);
    chk({tag, ".cmd_err"}, 32'(cmd_err), 0);
  endtask

  int err_base;

  initial begin
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    #1;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    chk_all_zero("reset");
    rst = 1'b1;
    tick(1'b0, 8'h00);

    // RF write, bytes two cycles apart
    tick(1'b1, 8'hAA);
    chk("wr.busy_after_op", 32'(frame_busy), 1);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h05);
    chk("wr.busy_after_addr", 32'(frame_busy), 1);
    chk("wr.no_early_wr", 32'(rf_wr_en), 0);
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h3C);
    chk("wr.wr_en", 32'(rf_wr_en), 1);
    chk("wr.addr", 32'(rf_addr), 5);
    chk("wr.data", 32'(rf_wr_data), 32'h3C);
    chk("wr.busy_done", 32'(frame_busy), 0);
    tick(1'b0, 8'h00);
    chk("wr.one_cycle", 32'(rf_wr_en), 0);

    // back-to-back write then read
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h11);
    chk("b2b.wr_en", 32'(rf_wr_en), 1);
    chk("b2b.wr_addr", 32'(rf_addr), 2);
    chk("b2b.wr_data", 32'(rf_wr_data), 32'h11);
    tick(1'b1, 8'hBB);
    chk("b2b.wr_off", 32'(rf_wr_en), 0);
    chk("b2b.busy_rd", 32'(frame_busy), 1);
    tick(1'b1, 8'h07);
    chk("b2b.rd_en", 32'(rf_rd_en), 1);
    chk("b2b.rd_addr", 32'(rf_addr), 7);
    tick(1'b0, 8'h00);
    chk("b2b.rd_off", 32'(rf_rd_en), 0);
    chk("b2b.no_err", 32'(err_cnt), 0);

    // ALU with operands, then without
    tick(1'b1, 8'hCC);
    tick(1'b1, 8'h0A);
    chk("alu.opa_wr", 32'(rf_wr_en), 1);
    chk("alu.opa_addr", 32'(rf_addr), 0);
    chk("alu.opa_data", 32'(rf_wr_data), 32'h0A);
    tick(1'b1, 8'h14);
    chk("alu.opb_wr", 32'(rf_wr_en), 1);
    chk("alu.opb_addr", 32'(rf_addr), 1);
    chk("alu.opb_data", 32'(rf_wr_data), 32'h14);
    chk("alu.opb_no_alu", 32'(alu_en), 0);
    tick(1'b1, 8'h03);
    chk("alu.en", 32'(alu_en), 1);
    chk("alu.fun", 32'(alu_fun), 3);
    chk("alu.fun_no_wr", 32'(rf_wr_en), 0);
    tick(1'b1, 8'hDD);
    chk("nop.no_en_yet", 32'(alu_en), 0);
    tick(1'b1, 8'h01);
    chk("nop.en", 32'(alu_en), 1);
    chk("nop.fun", 32'(alu_fun), 1);
    tick(1'b0, 8'h00);

    // malformed frames
    tick(1'b1, 8'h55);
    chk("bad_op.err", 32'(cmd_err), 1);
    chk("bad_op.busy", 32'(frame_busy), 0);
    tick(1'b1, 8'hBB);
    chk("bad_op.next_decoded", 32'(frame_busy), 1);
    tick(1'b1, 8'h1F);
    chk("bad_addr.err", 32'(cmd_err), 1);
    chk("bad_addr.no_rd", 32'(rf_rd_en), 0);
    chk("bad_addr.addr_held", 32'(rf_addr), 1);
    chk("bad_addr.busy", 32'(frame_busy), 0);
    tick(1'b1, 8'hDD);
    tick(1'b1, 8'h20);
    chk("bad_fun.err", 32'(cmd_err), 1);
    chk("bad_fun.no_alu", 32'(alu_en), 0);
    chk("bad_fun.fun_held", 32'(alu_fun), 1);
    tick(1'b0, 8'h00);
    chk("bad.err_count", 32'(err_cnt), 3);

    // timeout: 15 silent cycles keep the frame, the 16th aborts it
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h04);
    err_base = err_cnt;
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00);
    chk("tmo.no_err_early", 32'(err_cnt - err_base), 0);
    chk("tmo.busy_before", 32'(frame_busy), 1);
    tick(1'b0, 8'h00);
    chk("tmo.err", 32'(cmd_err), 1);
    chk("tmo.busy_after", 32'(frame_busy), 0);
    chk("tmo.no_wr", 32'(rf_wr_en), 0);
    tick(1'b1, 8'hBB);
    tick(1'b1, 8'h04);
    chk("tmo.rd_after", 32'(rf_rd_en), 1);
    chk("tmo.rd_addr", 32'(rf_addr), 4);

    // byte in the expiry cycle is accepted
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h04);
    err_base = err_cnt;
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00);
    tick(1'b1, 8'h77);
    chk("edge.wr_en", 32'(rf_wr_en), 1);
    chk("edge.addr", 32'(rf_addr), 4);
    chk("edge.data", 32'(rf_wr_data), 32'h77);
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);
    chk("edge.no_err", 32'(err_cnt - err_base), 0);

    // reset in the middle of a frame
    tick(1'b1, 8'hCC);
    tick(1'b1, 8'h0A);
    err_base = err_cnt;
    rst = 1'b0;
    tick(1'b0, 8'h00);
    chk_all_zero("midrst");
    rst = 1'b1;
    tick(1'b0, 8'h00);
    chk("midrst.idle", 32'(frame_busy), 0);
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h01);
    tick(1'b1, 8'hFF);
    chk("midrst.wr_en", 32'(rf_wr_en), 1);
    chk("midrst.addr", 32'(rf_addr), 1);
    chk("midrst.data", 32'(rf_wr_data), 32'hFF);
    tick(1'b0, 8'h00);
    chk("midrst.no_err", 32'(err_cnt - err_base), 0);

    chk("total_err_strobes", 32'(err_cnt), 4);
    chk("strobe_overlap", 32'(ovl_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
